// File: rtl/insn_loader.sv
// insn_loader: byte-stream boot loader for the core's instruction memory.
// Accepts COUNT (16-bit, little-endian) followed by COUNT little-endian
// 32-bit words, writes them from word 0 upward while holding the core in
// reset, then releases the core.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that must match before the core is released.
module insn_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                core_reset_q, core_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
`endif

  logic                xfer;
  logic [15:0]         count_full;
  logic                last_word;

  // A byte moves only while the loader is still collecting the image
  assign in_ready   = (state_q != S_DONE) && (state_q != S_ERR);
  assign xfer       = in_valid && in_ready;
  assign count_full = {in_data, count_q[7:0]};
  // Word counter is one bit wider than the address so COUNT==DEPTH compares cleanly
  assign last_word  = ((16'(word_cnt_q) + 16'd1) == count_q);

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

  // State and datapath registers; reset aborts any load in progress
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_LEN0;
      count_q      <= '0;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      asm_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      asm_q        <= asm_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  // Next-state selection from stream progress
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN0: if (xfer) state_d = S_LEN1;
      S_LEN1: begin
        if (xfer) begin
          if (count_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (count_full > 16'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer && (byte_cnt_q == 2'd3) && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (xfer) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
`endif
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Length capture, word assembly and memory write generation
  always_comb begin
    count_d     = count_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d       = xor_q;
    if (xfer && (state_q != S_CHK)) xor_d = xor_q ^ in_data;
`endif
    if (xfer) begin
      case (state_q)
        S_LEN0: count_d[7:0]  = in_data;
        S_LEN1: count_d[15:8] = in_data;
        S_DATA: begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = word_cnt_q[ADDR_W-1:0];
              mem_wdata_d = {in_data, asm_q};
              word_cnt_d  = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // Status outputs; core release lags DONE entry by one cycle so the final
  // write lands while the core is still held
  always_comb begin
    busy_d       = 1'b0;
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    core_reset_d = (state_q == S_DONE);
    case (state_d)
      S_LEN1, S_DATA: busy_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:          busy_d = 1'b1;
`endif
      default:        busy_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_insn_loader.sv
// tb_insn_loader: directed bench for insn_loader.
module tb_insn_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  int          vectors = 0;
  int          errs = 0;
  logic [7:0]  tb_xor = 8'h00;
  int          base_wr;

  // memory image observed through the write port
  logic [31:0] tb_mem [0:1023];
  int          wr_cnt = 0;
  logic [9:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  logic        prev_we = 1'b0;
  logic        b2b = 1'b0;

  insn_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_reset(core_reset), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      wr_cnt    <= wr_cnt + 1;
      last_addr <= mem_addr;
      last_data <= mem_wdata;
      if (prev_we) b2b <= 1'b1;
    end
    prev_we <= mem_we;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tb_xor   = tb_xor ^ b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    tick();
    reset  = 1'b1;
    tb_xor = 8'h00;
    tick();
    base_wr = wr_cnt;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"},   in_ready,   1'b1);
    check({tag, " mem_we"},     mem_we,     1'b0);
    check({tag, " mem_addr"},   mem_addr,   10'd0);
    check({tag, " mem_wdata"},  mem_wdata,  32'd0);
    check({tag, " core_reset"}, core_reset, 1'b0);
    check({tag, " busy"},       busy,       1'b0);
    check({tag, " done"},       done,       1'b0);
    check({tag, " error"},      error,      1'b0);
  endtask

  // trailing checksum (if built in) then bounded wait for done
  task automatic finish_load(input string tag);
    logic [7:0] sum;
    int i;
    sum = tb_xor;
`ifdef LOADER_CHECKSUM_EN
    send(sum);
`endif
    i = 0;
    while (!done && i < 20) begin
      tick();
      i++;
    end
    check({tag, " done"}, done, 1'b1);
  endtask

  initial begin
    // reset state
    reset = 1'b0;
    tick();
    check_reset_vals("por");
    reset = 1'b1;
    tick();

    // 1: basic load, back-to-back bytes
    do_reset();
    send(8'h02); send(8'h00);
    check("t1 busy", busy, 1'b1);
    send(8'h93); send(8'h80); send(8'h20); send(8'h03);
    check("t1 w0 we", mem_we, 1'b1);
    check("t1 w0 addr", mem_addr, 10'd0);
    check("t1 w0 data", mem_wdata, 32'h03208093);
    send(8'h13);
    check("t1 we one cycle", mem_we, 1'b0);
    send(8'hD1); send(8'h10); send(8'h40);
    check("t1 w1 addr", mem_addr, 10'd1);
    check("t1 w1 data", mem_wdata, 32'h4010D113);
`ifndef LOADER_CHECKSUM_EN
    check("t1 done at entry", done, 1'b1);
    check("t1 core held at entry", core_reset, 1'b0);
    check("t1 last we at entry", mem_we, 1'b1);
    check("t1 in_ready done", in_ready, 1'b0);
    check("t1 busy done", busy, 1'b0);
`endif
    finish_load("t1");
    tick();
    check("t1 core released", core_reset, 1'b1);
    check("t1 mem0", tb_mem[0], 32'h03208093);
    check("t1 mem1", tb_mem[1], 32'h4010D113);
    check("t1 writes", wr_cnt - base_wr, 2);
    check("t1 error", error, 1'b0);

    // 2: zero-length load
    do_reset();
    send(8'h00); send(8'h00);
    finish_load("t2");
    tick();
    check("t2 core released", core_reset, 1'b1);
    check("t2 writes", wr_cnt - base_wr, 0);

    // 3: oversize load, trailing bytes ignored
    do_reset();
    send(8'h01); send(8'h04);
    check("t3 error", error, 1'b1);
    check("t3 in_ready", in_ready, 1'b0);
    check("t3 busy", busy, 1'b0);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); gap(2);
    check("t3 error holds", error, 1'b1);
    check("t3 core held", core_reset, 1'b0);
    check("t3 not done", done, 1'b0);
    check("t3 writes", wr_cnt - base_wr, 0);

    // 4: stalled stream
    do_reset();
    send(8'h01); gap(3); send(8'h00); gap(3);
    send(8'hEF); gap(3); send(8'hBE); gap(3);
    send(8'hAD); gap(3);
    check("t4 no early write", wr_cnt - base_wr, 0);
    check("t4 busy stalled", busy, 1'b1);
    send(8'hDE);
    finish_load("t4");
    gap(2);
    check("t4 mem0", tb_mem[0], 32'hDEADBEEF);
    check("t4 writes", wr_cnt - base_wr, 1);
    check("t4 addr hold", mem_addr, 10'd0);
    check("t4 data hold", mem_wdata, 32'hDEADBEEF);
    check("t4 core released", core_reset, 1'b1);

    // 5: reset mid-load
    do_reset();
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    reset = 1'b0;
    tick();
    check_reset_vals("t5 rst");
    reset  = 1'b1;
    tb_xor = 8'h00;
    base_wr = wr_cnt;
    send(8'h01); send(8'h00); send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    finish_load("t5");
    tick();
    check("t5 mem0", tb_mem[0], 32'h11223344);
    check("t5 writes", wr_cnt - base_wr, 1);

    // 6: full-depth load, word i = i
    do_reset();
    send(8'h00); send(8'h04);
    check("t6 accepted", error, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      send(i[7:0]); send(i[15:8]); send(8'h00); send(8'h00);
    end
    finish_load("t6");
    gap(2);
    check("t6 writes", wr_cnt - base_wr, 1024);
    check("t6 last addr", last_addr, 10'd1023);
    check("t6 last data", last_data, 32'h000003FF);
    check("t6 mem0", tb_mem[0], 32'h00000000);
    check("t6 mem513", tb_mem[513], 32'h00000201);
    check("t6 error", error, 1'b0);
    check("t6 core released", core_reset, 1'b1);
    check("mem_we never back-to-back", b2b, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
